// File: rtl/solver_readout.sv
// solver_readout: scans every solver result RAM through the shared read port
// (solver-major, address-minor), colour-maps each signed byte to RGB332 and
// streams the pixels out over valid/ready. A 2-entry output FIFO plus a
// one-read-in-flight credit absorbs RAM latency and sink backpressure.
module solver_readout #(
    parameter int NUM_SOLVERS      = 1,
    parameter int WORDS_PER_SOLVER = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [5:0]        rd_solver_id,
    output logic [9:0]        rd_addr,
    output logic              rd_en,
    input  logic signed [7:0] rd_data_in,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_data,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam logic [5:0] ID_LAST   = 6'(NUM_SOLVERS - 1);
    localparam logic [9:0] ADDR_LAST = 10'(WORDS_PER_SOLVER - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      id_q, id_d;
    logic [9:0]      addr_q, addr_d;
    logic            inflight_q, inflight_d;
    logic            inflight_last_q, inflight_last_d;
    logic [1:0][8:0] fifo_q, fifo_d;     // entry = {colour, last}
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic [1:0]      occ_q, occ_d;

    logic            push, pop, final_addr, credit_ok;
    logic [1:0]      occ_after_pop;

    // Negative values are points inside the set and render black.
    function automatic logic [7:0] colour_map(input logic [7:0] v);
        if (v[7]) return 8'h00;
        return {v[2:0], v[5:3], v[6], v[0]};
    endfunction

    // Handshake, credit and read-issue decode. A pop in the same cycle frees
    // a slot, which is what keeps one pixel per cycle with ready held high.
    always_comb begin
        pix_valid     = (occ_q != 2'd0);
        pix_data      = fifo_q[rptr_q][8:1];
        pix_last      = fifo_q[rptr_q][0];
        pop           = pix_valid && pix_ready;
        push          = inflight_q;
        occ_after_pop = occ_q - {1'b0, pop};
        credit_ok     = (occ_after_pop + {1'b0, inflight_q}) < 2'd2;
        final_addr    = (id_q == ID_LAST) && (addr_q == ADDR_LAST);
        rd_en         = (state_q == READ) && credit_ok;
        rd_solver_id  = id_q;
        rd_addr       = addr_q;
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
    end

    // Read address walk and in-flight tracking.
    always_comb begin
        id_d            = id_q;
        addr_d          = addr_q;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && final_addr;
        if (state_q == IDLE && start) begin
            id_d   = '0;
            addr_d = '0;
        end else if (rd_en) begin
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                id_d   = id_q + 6'd1;
            end else begin
                addr_d = addr_q + 10'd1;
            end
        end
    end

    // Output FIFO: returning read data is always captured, stall or not.
    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wptr_q] = {colour_map(rd_data_in), inflight_last_q};
        wptr_d = wptr_q ^ push;
        rptr_d = rptr_q ^ pop;
        occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    if (rd_en && final_addr) state_d = DRAIN;
            DRAIN:   if (occ_d == 2'd0 && !inflight_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; reset drops buffered and in-flight data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            id_q            <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_q          <= '0;
            wptr_q          <= 1'b0;
            rptr_q          <= 1'b0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_q          <= fifo_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            occ_q           <= occ_d;
        end
    end

endmodule
